// File: rtl/im_loader.sv
// Byte-stream instruction-memory loader: 16-bit word count header, then N big-endian 32-bit words.
// Optional trailing checksum word enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int unsigned IM_AW     = 10,
  parameter int unsigned MAX_WORDS = 2**IM_AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             im_we,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] S_HDR_HI = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CKSUM  = 3'd3;
`endif
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             r_hold;
  logic             r_done;
  logic             r_err;
  logic [23:0]      r_shift;
  logic [1:0]       r_bcnt;
  logic [15:0]      r_left;
  logic [IM_AW-1:0] r_addr;
  logic             r_we;
  logic [31:0]      r_wdata;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]      r_sum;
`endif

  logic        w_xfer;
  logic        w_byte_last;
  logic        w_rearm;
  logic [31:0] w_word;
  logic [15:0] w_n;
  logic        w_n_big;

  // Accepting states are encoded 0..3, so bit 2 clear means ready.
  assign in_ready    = ~reset & ~r_state[2];
  assign w_xfer      = in_valid & in_ready;
  assign w_byte_last = (r_bcnt == 2'd3);
  assign w_word      = {r_shift, in_data};
  assign w_n         = {r_shift[7:0], in_data};
  assign w_n_big     = (32'(w_n) > MAX_WORDS);
  assign w_rearm     = start & ((r_state == S_DONE) | (r_state == S_ERR));

  assign im_we    = r_we;
  assign im_addr  = r_addr;
  assign im_wdata = r_wdata;
  assign cpu_hold = r_hold;
  assign done     = r_done;
  assign err      = r_err;

  // State register; status flags are registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_HDR_HI;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold  <= (w_next != S_DONE);
      r_done  <= (w_next == S_DONE);
      r_err   <= (w_next == S_ERR);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR_HI: if (w_xfer) w_next = S_HDR_LO;
      S_HDR_LO: begin
        if (w_xfer) begin
          if (w_n_big)
            w_next = S_ERR;
          else if (w_n == 16'd0)
`ifdef IM_LOADER_CHECKSUM_EN
            w_next = S_CKSUM;
`else
            w_next = S_DONE;
`endif
          else
            w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_xfer && w_byte_last && (r_left == 16'd1))
`ifdef IM_LOADER_CHECKSUM_EN
          w_next = S_CKSUM;
`else
          w_next = S_DONE;
`endif
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CKSUM: if (w_xfer && w_byte_last) w_next = (w_word == r_sum) ? S_DONE : S_ERR;
`endif
      S_DONE:  if (start) w_next = S_HDR_HI;
      S_ERR:   if (start) w_next = S_HDR_HI;
      default: w_next = S_HDR_HI;
    endcase
  end

  // Word assembly, write strobe and index; index advances after each write while more words follow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= 24'd0;
      r_bcnt  <= 2'd0;
      r_left  <= 16'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= 32'd0;
`ifdef IM_LOADER_CHECKSUM_EN
      r_sum   <= 32'd0;
`endif
    end else begin
      r_we <= 1'b0;
      if (w_xfer) r_shift <= w_word[23:0];
      if (w_rearm) begin
        r_addr <= '0;
        r_bcnt <= 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
        r_sum  <= 32'd0;
`endif
      end else begin
        if (r_we && (r_state == S_DATA)) r_addr <= r_addr + IM_AW'(1);
        if (w_xfer && (r_state == S_HDR_LO)) begin
          r_left <= w_n;
          r_bcnt <= 2'd0;
        end
        if (w_xfer && (r_state == S_DATA)) begin
          r_bcnt <= r_bcnt + 2'd1;
          if (w_byte_last) begin
            r_we    <= 1'b1;
            r_wdata <= w_word;
            r_left  <= r_left - 16'd1;
`ifdef IM_LOADER_CHECKSUM_EN
            r_sum   <= r_sum + w_word;
`endif
          end
        end
`ifdef IM_LOADER_CHECKSUM_EN
        if (w_xfer && (r_state == S_CKSUM)) r_bcnt <= r_bcnt + 2'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: streams, stalls, oversize header, mid-load reset, empty program.
// Checksum vectors are exercised when IM_LOADER_CHECKSUM_EN is defined.
module tb_im_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  prog[10];

  im_loader #(.IM_AW(10), .MAX_WORDS(1024)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (im_we) begin
      wa.push_back(32'(im_addr));
      wd.push_back(im_wdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_prog(input int gap);
    for (int i = 0; i < 10; i++) send_byte(prog[i], gap);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clock);
  endtask

  task automatic check_prog_result(input string tag);
    check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check({tag, "_a0"}, wa[0], 32'd0);
      check({tag, "_d0"}, wd[0], 32'h20080005);
      check({tag, "_a1"}, wa[1], 32'd1);
      check({tag, "_d1"}, wd[1], 32'h20090007);
    end
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"},  32'(err), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_rdy"},  32'(in_ready), 32'd0);
  endtask

  task automatic check_err(input string tag);
    check({tag, "_err"},  32'(err), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_rdy"},  32'(in_ready), 32'd0);
  endtask

  task automatic rearm(input string tag);
    pulse_start();
    check({tag, "_rearm_rdy"},  32'(in_ready), 32'd1);
    check({tag, "_rearm_done"}, 32'(done), 32'd0);
    check({tag, "_rearm_err"},  32'(err), 32'd0);
    check({tag, "_rearm_hold"}, 32'(cpu_hold), 32'd1);
    wa.delete();
    wd.delete();
  endtask

  task automatic send_cksum(input logic [31:0] v, input int gap);
    send_byte(v[31:24], gap);
    send_byte(v[23:16], gap);
    send_byte(v[15:8], gap);
    send_byte(v[7:0], gap);
  endtask

  initial begin
    prog = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_rdy",   32'(in_ready), 32'd0);
    check("rst_we",    32'(im_we), 32'd0);
    check("rst_addr",  32'(im_addr), 32'd0);
    check("rst_wdata", im_wdata, 32'd0);
    check("rst_hold",  32'(cpu_hold), 32'd1);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_rdy", 32'(in_ready), 32'd1);

    // Back-to-back stream
    send_prog(0);
`ifdef IM_LOADER_CHECKSUM_EN
    check("b2b_hold_pre_ck", 32'(cpu_hold), 32'd1);
    send_cksum(32'h4011000C, 0);
`endif
    settle();
    check_prog_result("b2b");
    check_done("b2b");

    // Same stream with 3-cycle gaps
    rearm("gap");
    send_prog(3);
`ifdef IM_LOADER_CHECKSUM_EN
    send_cksum(32'h4011000C, 3);
`endif
    settle();
    check_prog_result("gap");
    check_done("gap");

    // Oversize header FF FF
    rearm("ovf");
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    settle();
    check_err("ovf");
    check("ovf_nwr", 32'(wa.size()), 32'd0);

    // Just above MAX_WORDS (0x0401)
    rearm("ovf1");
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    settle();
    check_err("ovf1");

    // Reset after 2 bytes of word 0
    rearm("mid");
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_rdy",  32'(in_ready), 32'd0);
    check("mid_rst_we",   32'(im_we), 32'd0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd1);
    reset = 1'b0;
    settle();
    check("mid_nwr", 32'(wa.size()), 32'd0);
    check("mid_addr", 32'(im_addr), 32'd0);
    send_prog(0);
`ifdef IM_LOADER_CHECKSUM_EN
    send_cksum(32'h4011000C, 0);
`endif
    settle();
    check_prog_result("reload");
    check_done("reload");

`ifdef IM_LOADER_CHECKSUM_EN
    // Wrong checksum
    rearm("badck");
    send_prog(0);
    send_cksum(32'h4011000D, 0);
    settle();
    check_prog_result("badck");
    check_err("badck");
`endif

    // Empty program
    rearm("empty");
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    check("empty_ck_rdy", 32'(in_ready), 32'd1);
    send_cksum(32'h00000000, 0);
`endif
    settle();
    check("empty_nwr", 32'(wa.size()), 32'd0);
    check_done("empty");

    // start is ignored while loading
    rearm("ign");
    send_byte(8'h00, 0);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    send_cksum(32'hDEADBEEF, 0);
`endif
    settle();
    check("ign_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("ign_a0", wa[0], 32'd0);
      check("ign_d0", wd[0], 32'hDEADBEEF);
    end
    check_done("ign");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
